// File: rtl/pong_pkg.sv
// Shared definitions for the ping-pong game blocks.
//   state_t        : serve sequencer FSM states
//   WIN_SCORE_DEF  : default terminal score, shared with game_state
//   DIR_P1/DIR_P2  : serve direction encoding
//   sat_inc()      : 4-bit increment that stops at a limit
package pong_pkg;

  typedef enum logic [1:0] {
    SERVE_WAIT = 2'd0,
    PLAY       = 2'd1,
    OVER       = 2'd2
  } state_t;

  localparam int   WIN_SCORE_DEF = 11;
  localparam logic DIR_P1        = 1'b0;
  localparam logic DIR_P2        = 1'b1;

  function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
    return (s >= lim) ? lim : s + 4'd1;
  endfunction

endpackage

// File: rtl/tick_sync.sv
// Synchronizer plus rising-edge detector.
//   clk    : system clock
//   reset  : synchronous, active-low
//   in     : asynchronous (or merely unregistered) level
//   pulse  : one clk cycle high per rising edge of in
// STAGES is the number of capture flops ahead of the edge register
// (2 for a true CDC synchronizer, 1 for a plain registered input).
// pulse is decoded combinationally from the last two flops, so a rise
// seen by the first flop at edge n is consumed by the caller at edge
// n+STAGES.
module tick_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  // sync_pipe[0] is newest; sync_pipe[STAGES] holds the previous value
  // of the synchronized level for edge detection.
  logic [STAGES:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (!reset) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[STAGES-1:0], in};
  end

  assign pulse = sync_pipe[STAGES-1] & ~sync_pipe[STAGES];

endmodule

// File: rtl/score_keeper.sv
// Point scoring and serve sequencer.
//   clk, reset     : system clock, synchronous active-low reset
//   clk_1ms        : 1 kHz square wave, sampled as data
//   p1_miss/p2_miss: level miss flags from ball logic (rising edge counts)
//   p1_score/p2_score : registered 4-bit scores, saturate at WIN_SCORE
//   ball_hold      : park the ball at centre
//   serve          : one-cycle launch pulse
//   serve_dir      : launch direction (0 toward p1, 1 toward p2)
//   game_over      : set when a score reaches WIN_SCORE, cleared only by reset
module score_keeper
  import pong_pkg::*;
#(
  parameter int   WIN_SCORE      = WIN_SCORE_DEF,
  parameter int   SERVE_DELAY_MS = 1000,
  parameter logic FIRST_SERVE    = DIR_P1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_1ms,
  input  logic       p1_miss,
  input  logic       p2_miss,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       ball_hold,
  output logic       serve,
  output logic       serve_dir,
  output logic       game_over
);

  localparam int              CW   = $clog2(SERVE_DELAY_MS + 1);
  localparam logic [CW-1:0]   LOAD = CW'(SERVE_DELAY_MS);
  localparam logic [3:0]      WIN4 = 4'(WIN_SCORE);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          tick, p1_ev, p2_ev;
  logic [3:0]    p1_next, p2_next;

  tick_sync #(.STAGES(2)) u_tick (.clk(clk), .reset(reset), .in(clk_1ms), .pulse(tick));
  tick_sync #(.STAGES(1)) u_p1   (.clk(clk), .reset(reset), .in(p1_miss), .pulse(p1_ev));
  tick_sync #(.STAGES(1)) u_p2   (.clk(clk), .reset(reset), .in(p2_miss), .pulse(p2_ev));

  assign p1_next = sat_inc(p1_score, WIN4);
  assign p2_next = sat_inc(p2_score, WIN4);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SERVE_WAIT;
      cnt       <= LOAD;
      p1_score  <= 4'd0;
      p2_score  <= 4'd0;
      ball_hold <= 1'b1;
      serve     <= 1'b0;
      serve_dir <= FIRST_SERVE;
      game_over <= 1'b0;
    end else begin
      serve <= 1'b0;
      case (state)
        SERVE_WAIT: begin
          // Counter stays at 1 after the serve; it is reloaded on every
          // entry to SERVE_WAIT, so its value in PLAY does not matter.
          if (tick) begin
            if (cnt == CW'(1)) begin
              serve     <= 1'b1;
              ball_hold <= 1'b0;
              state     <= PLAY;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        PLAY: begin
          if (p1_ev && p2_ev) begin
            // Let: replay the point, same direction.
            state     <= SERVE_WAIT;
            ball_hold <= 1'b1;
            cnt       <= LOAD;
          end else if (p1_ev) begin
            p2_score  <= p2_next;
            serve_dir <= DIR_P2;
            ball_hold <= 1'b1;
            if (p2_next == WIN4) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              state <= SERVE_WAIT;
              cnt   <= LOAD;
            end
          end else if (p2_ev) begin
            p1_score  <= p1_next;
            serve_dir <= DIR_P1;
            ball_hold <= 1'b1;
            if (p1_next == WIN4) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              state <= SERVE_WAIT;
              cnt   <= LOAD;
            end
          end
        end
        OVER: ;  // frozen until reset
        default: begin
          state     <= SERVE_WAIT;
          ball_hold <= 1'b1;
          cnt       <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper with SERVE_DELAY_MS=3, FIRST_SERVE=0, WIN=11.
// Output vector layout: [11:8] p1_score, [7:4] p2_score, [3] ball_hold,
// [2] serve, [1] serve_dir, [0] game_over.
module tb_score_keeper;

  localparam int DELAY = 3;
  localparam int WIN   = 11;

  logic       clk = 1'b0;
  logic       reset, clk_1ms, p1_miss, p2_miss;
  logic [3:0] p1_score, p2_score;
  logic       ball_hold, serve, serve_dir, game_over;

  int chk = 0;
  int err = 0;

  score_keeper #(.WIN_SCORE(WIN), .SERVE_DELAY_MS(DELAY), .FIRST_SERVE(1'b0)) dut (
    .clk(clk), .reset(reset), .clk_1ms(clk_1ms), .p1_miss(p1_miss), .p2_miss(p2_miss),
    .p1_score(p1_score), .p2_score(p2_score), .ball_hold(ball_hold), .serve(serve),
    .serve_dir(serve_dir), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Event-level view of the game: input histories give the edge at which
  // a ms rise or a miss rise takes effect; the game itself is a mode plus
  // a count of ticks seen while waiting.
  logic [2:0] h_ms;          // [0]=sample at previous edge, [1]=two back, [2]=three back
  logic [1:0] h_m1, h_m2;    // [0]=previous edge, [1]=two back
  int   m_mode;              // 0 waiting, 1 playing, 2 over
  int   m_ticks, m_s1, m_s2;
  logic m_dir, m_serve;

  task automatic model_edge(input logic r, ms, m1, m2);
    logic tk, e1, e2;
    if (!r) begin
      h_ms = '0; h_m1 = '0; h_m2 = '0;
      m_mode = 0; m_ticks = 0; m_s1 = 0; m_s2 = 0; m_dir = 1'b0; m_serve = 1'b0;
      return;
    end
    tk = h_ms[1] & ~h_ms[2];
    e1 = h_m1[0] & ~h_m1[1];
    e2 = h_m2[0] & ~h_m2[1];
    m_serve = 1'b0;
    if (m_mode == 0) begin
      if (tk) begin
        m_ticks++;
        if (m_ticks == DELAY) begin m_serve = 1'b1; m_mode = 1; end
      end
    end else if (m_mode == 1) begin
      if (e1 && e2) begin
        m_mode = 0; m_ticks = 0;
      end else if (e1 || e2) begin
        if (e1) begin if (m_s2 < WIN) m_s2++; m_dir = 1'b1; end
        else    begin if (m_s1 < WIN) m_s1++; m_dir = 1'b0; end
        m_mode  = (m_s1 == WIN || m_s2 == WIN) ? 2 : 0;
        m_ticks = 0;
      end
    end
    h_ms = {h_ms[1:0], ms};
    h_m1 = {h_m1[0], m1};
    h_m2 = {h_m2[0], m2};
  endtask

  function automatic logic [11:0] ov(input int a, input int b, input logic h, s, d, o);
    return {a[3:0], b[3:0], h, s, d, o};
  endfunction

  function automatic logic [11:0] dvec();
    return {p1_score, p2_score, ball_hold, serve, serve_dir, game_over};
  endfunction

  function automatic logic [11:0] mvec();
    return ov(m_s1, m_s2, m_mode != 1, m_serve, m_dir, m_mode == 2);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model, clock, compare against model.
  task automatic cyc(input logic r, ms, m1, m2);
    reset = r; clk_1ms = ms; p1_miss = m1; p2_miss = m2;
    model_edge(r, ms, m1, m2);
    @(posedge clk); #1;
    check("model", {20'd0, dvec()}, {20'd0, mvec()});
  endtask

  task automatic miss(input logic m1, m2);
    cyc(1'b1, 1'b0, m1, m2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // From SERVE_WAIT with quiet ms history: ms rises on odd cycles, so the
  // third tick is consumed at cycle 7.
  task automatic serve_after(input string nm, input logic m1h);
    int at = 0;
    cyc(1'b1, 1'b0, m1h, 1'b0);
    cyc(1'b1, 1'b0, m1h, 1'b0);
    for (int i = 1; i <= 12 && at == 0; i++) begin
      cyc(1'b1, logic'(i % 2 == 1), m1h, 1'b0);
      if (serve) at = i;
    end
    check(nm, at, 7);
    cyc(1'b1, 1'b0, m1h, 1'b0);
    cyc(1'b1, 1'b0, m1h, 1'b0);
  endtask

  typedef struct {
    logic        rst, ms, m1, m2;
    logic [11:0] exp;
  } vec_t;

  initial begin
    vec_t tbl[11];
    logic ms_r;
    int   saw;

    // Reset then idle: three ticks consumed at rows 3, 6, 8.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, ov(0, 0, 1, 0, 0, 0)};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, ov(0, 0, 1, 0, 0, 0)};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, ov(0, 0, 1, 0, 0, 0)};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, ov(0, 0, 1, 0, 0, 0)};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, ov(0, 0, 1, 0, 0, 0)};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, ov(0, 0, 1, 0, 0, 0)};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, ov(0, 0, 1, 0, 0, 0)};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, ov(0, 0, 1, 0, 0, 0)};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, ov(0, 0, 0, 1, 0, 0)};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 0)};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 0)};

    reset = 1'b0; clk_1ms = 1'b0; p1_miss = 1'b0; p2_miss = 1'b0;
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].rst, tbl[i].ms, tbl[i].m1, tbl[i].m2);
      check($sformatf("tbl%0d", i), {20'd0, dvec()}, {20'd0, tbl[i].exp});
    end

    // Single p2 miss in PLAY
    miss(1'b0, 1'b1);
    check("p2_miss", {20'd0, dvec()}, {20'd0, ov(1, 0, 1, 0, 0, 0)});
    serve_after("serve_after_p2", 1'b0);

    // Simultaneous miss: let
    miss(1'b1, 1'b1);
    check("let", {20'd0, dvec()}, {20'd0, ov(1, 0, 1, 0, 0, 0)});
    serve_after("serve_after_let", 1'b0);

    // p1 miss, then ignored miss in SERVE_WAIT, then miss held across serve
    miss(1'b1, 1'b0);
    check("p1_miss", {20'd0, dvec()}, {20'd0, ov(1, 1, 1, 0, 1, 0)});
    miss(1'b0, 1'b1);
    check("wait_ignored", {20'd0, dvec()}, {20'd0, ov(1, 1, 1, 0, 1, 0)});
    serve_after("serve_held", 1'b1);
    check("held_miss", {20'd0, dvec()}, {20'd0, ov(1, 1, 0, 0, 1, 0)});
    cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in PLAY, then reset mid-countdown restarts at 3
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_play", {20'd0, dvec()}, {20'd0, ov(0, 0, 1, 0, 0, 0)});
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_count", {20'd0, dvec()}, {20'd0, ov(0, 0, 1, 0, 0, 0)});
    serve_after("serve_restart", 1'b0);

    // Win: 11 p1 misses
    for (int n = 1; n <= WIN; n++) begin
      miss(1'b1, 1'b0);
      if (n < WIN) serve_after("serve_win_seq", 1'b0);
    end
    check("win", {20'd0, dvec()}, {20'd0, ov(0, 11, 1, 0, 1, 1)});

    // Frozen in OVER: misses and 10 ms rises
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, logic'(i % 2), logic'(i % 3 == 0), logic'(i % 4 == 1));
      if (serve) saw++;
    end
    check("over_no_serve", saw, 0);
    check("over_frozen", {20'd0, dvec()}, {20'd0, ov(0, 11, 1, 0, 1, 1)});

    // Reset from OVER
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_over", {20'd0, dvec()}, {20'd0, ov(0, 0, 1, 0, 0, 0)});

    // Random traffic against the model
    ms_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) ms_r = ~ms_r;
      cyc(logic'($urandom_range(0, 599) != 0), ms_r,
          logic'($urandom_range(0, 5) == 0), logic'($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
